// File: rtl/insn_fetch_queue_pkg.sv
// Shared types for the fetch/decode boundary: the buffered fetch entry and the decoded uop.
// Machine widths live here so the queue, its interface and the decoder agree.
package insn_fetch_queue_pkg;

    localparam int M_WIDTH   = 32;
    localparam int LG_PHT_SZ = 12;
    localparam bit ENABLE_CYCLE_ACCOUNTING = 1'b1;

    typedef struct packed {
        logic [31:0]          insn;
        logic [M_WIDTH-1:0]   pc;
        logic                 pred;
        logic [LG_PHT_SZ-1:0] pht_idx;
        logic [M_WIDTH-1:0]   pred_target;
        logic [63:0]          fetch_cycle;
    } fq_entry_t;

    typedef enum logic [2:0] {
        UOP_ALU, UOP_LOAD, UOP_STORE, UOP_BRANCH, UOP_JUMP, UOP_SYSTEM
    } uop_kind_t;

    typedef struct packed {
        uop_kind_t          kind;
        logic [4:0]         rd;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [31:0]        imm;
        logic [M_WIDTH-1:0] pc;
    } uop_t;

endpackage

// File: rtl/insn_fetch_queue_if.sv
// Fetch-side and decode-side valid/ready handshakes of the instruction fetch queue.
// The queue uses the slave modport; the surrounding pipeline uses master.
interface insn_fetch_queue_if;
    import insn_fetch_queue_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_insn;
    logic [M_WIDTH-1:0]   in_pc;
    logic                 in_pred;
    logic [LG_PHT_SZ-1:0] in_pht_idx;
    logic [M_WIDTH-1:0]   in_pred_target;
    logic [63:0]          in_fetch_cycle;

    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_insn;
    logic [M_WIDTH-1:0]   out_pc;
    logic                 out_pred;
    logic [LG_PHT_SZ-1:0] out_pht_idx;
    logic [M_WIDTH-1:0]   out_pred_target;
    logic [63:0]          out_fetch_cycle;

    modport slave (
        input  in_valid, in_insn, in_pc, in_pred, in_pht_idx, in_pred_target, in_fetch_cycle,
        output in_ready,
        output out_valid, out_insn, out_pc, out_pred, out_pht_idx, out_pred_target, out_fetch_cycle,
        input  out_ready
    );

    modport master (
        output in_valid, in_insn, in_pc, in_pred, in_pht_idx, in_pred_target, in_fetch_cycle,
        input  in_ready,
        input  out_valid, out_insn, out_pc, out_pred, out_pht_idx, out_pred_target, out_fetch_cycle,
        output out_ready
    );

endinterface

// File: rtl/insn_fetch_queue_fq_ptr.sv
// Wrapped queue pointer: low bits index the array, the extra MSB is the wrap bit
// that tells full from empty. Clear beats increment.
module fq_ptr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q, ptr_d;

    // NOTE: default assignment first keeps every path driven, so no latch is inferred.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i)      ptr_d = '0;
        else if (inc_i) ptr_d = ptr_q + W'(1);
    end

    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/insn_fetch_queue.sv
// Decoupling FIFO between instruction fetch and decode. Status outputs come only from the
// registered pointers; flush empties the queue and overrides any concurrent push or pop.
module insn_fetch_queue
    import insn_fetch_queue_pkg::*;
#(
    parameter int LG_DEPTH    = 3,
    parameter int AFULL_SLACK = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    insn_fetch_queue_if.slave    fq,
    output logic                 afull,
    output logic [LG_DEPTH:0]    occupancy
);

    localparam int DEPTH = 1 << LG_DEPTH;
    localparam logic [LG_DEPTH:0] DEPTH_W = (LG_DEPTH+1)'(DEPTH);
    localparam logic [LG_DEPTH:0] SLACK_W = (LG_DEPTH+1)'(AFULL_SLACK);

    logic [LG_DEPTH:0] head, tail;
    logic [LG_DEPTH:0] free_cnt;
    logic              full, empty, push, pop;
    fq_entry_t         wr_entry, rd_entry;
    fq_entry_t         mem_q [DEPTH];

    assign empty = (head == tail);
    assign full  = (head[LG_DEPTH-1:0] == tail[LG_DEPTH-1:0]) && (head[LG_DEPTH] != tail[LG_DEPTH]);

    assign push = fq.in_valid && !full  && !flush;
    assign pop  = fq.out_ready && !empty && !flush;

    fq_ptr #(.W(LG_DEPTH+1)) u_head (
        .clk(clk), .reset(reset), .clr_i(flush), .inc_i(pop),  .ptr_o(head)
    );

    fq_ptr #(.W(LG_DEPTH+1)) u_tail (
        .clk(clk), .reset(reset), .clr_i(flush), .inc_i(push), .ptr_o(tail)
    );

    always_comb begin
        wr_entry             = '0;
        wr_entry.insn        = fq.in_insn;
        wr_entry.pc          = fq.in_pc;
        wr_entry.pred        = fq.in_pred;
        wr_entry.pht_idx     = fq.in_pht_idx;
        wr_entry.pred_target = fq.in_pred_target;
        if (ENABLE_CYCLE_ACCOUNTING) wr_entry.fetch_cycle = fq.in_fetch_cycle;
    end

    // NOTE: the array is deliberately not reset; the pointers alone define which slots are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[tail[LG_DEPTH-1:0]] <= wr_entry;
    end

    assign rd_entry = mem_q[head[LG_DEPTH-1:0]];

    assign fq.in_ready        = !full;
    assign fq.out_valid       = !empty;
    assign fq.out_insn        = rd_entry.insn;
    assign fq.out_pc          = rd_entry.pc;
    assign fq.out_pred        = rd_entry.pred;
    assign fq.out_pht_idx     = rd_entry.pht_idx;
    assign fq.out_pred_target = rd_entry.pred_target;
    assign fq.out_fetch_cycle = rd_entry.fetch_cycle;

    assign occupancy = tail - head;
    assign free_cnt  = DEPTH_W - occupancy;
    assign afull     = (free_cnt <= SLACK_W);

endmodule

// File: tb/tb_insn_fetch_queue.sv
// Directed bench for insn_fetch_queue: a queue-based reference model checked every cycle,
// plus hand-computed expectations at the interesting points of each scenario.
module tb_insn_fetch_queue;
  import insn_fetch_queue_pkg::*;

  logic clk, reset, flush, afull;
  logic [3:0] occupancy;
  int checks = 0;
  int failures = 0;
  bit cmp_en = 0;

  insn_fetch_queue_if fq_bus ();

  insn_fetch_queue #(.LG_DEPTH(3), .AFULL_SLACK(2)) dut (
    .clk(clk), .reset(reset), .flush(flush), .fq(fq_bus),
    .afull(afull), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] insn_of(input logic [31:0] pc);
    insn_of = 32'h0000_0013 ^ {pc[11:0], 20'h0};
  endfunction

  function automatic fq_entry_t entry_of(input logic [31:0] pc);
    entry_of.insn        = insn_of(pc);
    entry_of.pc          = pc;
    entry_of.pred        = pc[2];
    entry_of.pht_idx     = pc[13:2];
    entry_of.pred_target = pc + 32'h40;
    entry_of.fetch_cycle = {32'h0000_abcd, pc};
  endfunction

  // Reference model: an ordered list of buffered entries, capacity 8.
  fq_entry_t model_q[$];
  bit m_push, m_pop;
  always @(posedge clk or negedge reset) begin
    if (!reset || flush) begin
      model_q.delete();
    end else begin
      m_pop  = (model_q.size() > 0) && fq_bus.out_ready;
      m_push = fq_bus.in_valid && (model_q.size() < 8);
      if (m_pop) void'(model_q.pop_front());
      if (m_push) model_q.push_back(entry_of(fq_bus.in_pc));
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_out_valid", fq_bus.out_valid, model_q.size() != 0);
      check("cmp_in_ready",  fq_bus.in_ready,  model_q.size() < 8);
      check("cmp_occupancy", occupancy,        model_q.size());
      check("cmp_afull",     afull,            (8 - model_q.size()) <= 2);
      if (model_q.size() != 0) begin
        check("cmp_insn",        fq_bus.out_insn,        model_q[0].insn);
        check("cmp_pc",          fq_bus.out_pc,          model_q[0].pc);
        check("cmp_pred",        fq_bus.out_pred,        model_q[0].pred);
        check("cmp_pht_idx",     fq_bus.out_pht_idx,     model_q[0].pht_idx);
        check("cmp_pred_target", fq_bus.out_pred_target, model_q[0].pred_target);
        check("cmp_fetch_cycle", fq_bus.out_fetch_cycle, model_q[0].fetch_cycle);
      end
    end
  end

  task automatic drive(input logic iv, input logic [31:0] pc, input logic ordy, input logic fl);
    fq_entry_t e;
    e = entry_of(pc);
    fq_bus.in_valid       = iv;
    fq_bus.in_insn        = e.insn;
    fq_bus.in_pc          = e.pc;
    fq_bus.in_pred        = e.pred;
    fq_bus.in_pht_idx     = e.pht_idx;
    fq_bus.in_pred_target = e.pred_target;
    fq_bus.in_fetch_cycle = e.fetch_cycle;
    fq_bus.out_ready      = ordy;
    flush                 = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    fq_bus.in_valid = 1'b0;
    fq_bus.in_insn = '0;
    fq_bus.in_pc = '0;
    fq_bus.in_pred = 1'b0;
    fq_bus.in_pht_idx = '0;
    fq_bus.in_pred_target = '0;
    fq_bus.in_fetch_cycle = '0;
    fq_bus.out_ready = 1'b0;

    #3;
    check("rst_out_valid", fq_bus.out_valid, 1'b0);
    check("rst_in_ready",  fq_bus.in_ready,  1'b1);
    check("rst_afull",     afull,            1'b0);
    check("rst_occupancy", occupancy,        4'd0);
    #9 reset = 1'b1;
    cmp_en = 1'b1;
    @(posedge clk);
    #1;

    // Single push becomes visible one cycle later.
    drive(1'b1, 32'h1000, 1'b0, 1'b0);
    check("first_out_valid", fq_bus.out_valid, 1'b1);
    check("first_pc",        fq_bus.out_pc,    32'h1000);
    check("first_insn",      fq_bus.out_insn,  32'h0000_0013);
    check("first_occupancy", occupancy,        4'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("first_pop_occ", occupancy, 4'd0);

    // Fill to full, 9th dropped, drain in order.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h1000 + 32'(4 * i), 1'b0, 1'b0);
      check("fill_afull",    afull,           (i + 1) >= 6);
      check("fill_in_ready", fq_bus.in_ready, (i + 1) < 8);
    end
    drive(1'b1, 32'h1020, 1'b0, 1'b0);
    check("ninth_occupancy", occupancy, 4'd8);
    for (int i = 0; i < 8; i++) begin
      check("drain_pc", fq_bus.out_pc, 32'h1000 + 32'(4 * i));
      drive(1'b0, 32'h0, 1'b1, 1'b0);
    end
    check("drain_empty", fq_bus.out_valid, 1'b0);

    // Steady-state push+pop for 40 cycles across several pointer wraps.
    drive(1'b1, 32'h2000, 1'b0, 1'b0);
    for (int i = 1; i <= 40; i++) begin
      drive(1'b1, 32'h2000 + 32'(4 * i), 1'b1, 1'b0);
      check("stream_occ", occupancy,     4'd1);
      check("stream_pc",  fq_bus.out_pc, 32'h2000 + 32'(4 * i));
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush with concurrent push and pop.
    for (int i = 0; i < 5; i++) drive(1'b1, 32'h3000 + 32'(4 * i), 1'b0, 1'b0);
    drive(1'b1, 32'h3100, 1'b1, 1'b1);
    check("flush_out_valid", fq_bus.out_valid, 1'b0);
    check("flush_occupancy", occupancy,        4'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("flush_no_store",  fq_bus.out_valid, 1'b0);

    // Full with push and pop: pop happens, push refused.
    for (int i = 0; i < 8; i++) drive(1'b1, 32'h4000 + 32'(4 * i), 1'b0, 1'b0);
    drive(1'b1, 32'h4100, 1'b1, 1'b0);
    check("full_pp_occ", occupancy,     4'd7);
    check("full_pp_pc",  fq_bus.out_pc, 32'h4004);
    for (int i = 0; i < 7; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("full_pp_drained", fq_bus.out_valid, 1'b0);

    // Asynchronous reset between edges with entries buffered.
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h5000 + 32'(4 * i), 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("pre_areset_occ", occupancy, 4'd4);
    #2 reset = 1'b0;
    #1;
    check("areset_out_valid", fq_bus.out_valid, 1'b0);
    check("areset_in_ready",  fq_bus.in_ready,  1'b1);
    check("areset_occupancy", occupancy,        4'd0);
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_areset_valid", fq_bus.out_valid, 1'b0);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
